// File: rtl/filter_iir_pkg.sv
// Shared defaults and sizing helper for the first-order IIR smoothing filter.
package filter_iir_pkg;

  localparam int N_DEF        = 16;
  localparam int NI_DEF       = 16;
  localparam int IIRCONST_DEF = 6;
  localparam int FRAC_DEF     = 7;

  // The state register carries the input integer bits plus FRAC fractional bits.
  function automatic int state_w(input int ni, input int frac);
    return ni + frac;
  endfunction

endpackage

// File: rtl/filter_iir_if.sv
// Sample-in / filtered-out bundle. The producer drives in+write, the filter drives out.
interface filter_iir_if #(
    parameter int N  = 16,
    parameter int NI = 16
) ();
    // Handshake: write=1 on a rising edge means that in is consumed at that
    // edge. There is no ready; the filter accepts one sample on every cycle.
    logic signed [NI-1:0] in;
    logic                 write;
    logic signed [N-1:0]  out;

    modport master (output in, output write, input out);
    modport slave  (input in, input write, output out);
endinterface

// File: rtl/filter_iir.sv
// Exponential smoothing filter: acc += ((in << FRAC) - acc) >>> IIRCONST, out = acc >>> FRAC.
module filter_iir
    import filter_iir_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int NI       = NI_DEF,
    parameter int IIRCONST = IIRCONST_DEF,
    parameter int FRAC     = FRAC_DEF    // must be >= IIRCONST
) (
    input  logic          clk,
    input  logic          rst,
    filter_iir_if.slave   bus
);

    localparam int SW = state_w(NI, FRAC);
    localparam int DW = SW + 1;

    logic signed [SW-1:0] r_acc;
    logic signed [N-1:0]  r_out;
    logic signed [DW-1:0] w_in_scaled;
    logic signed [DW-1:0] w_diff;
    logic signed [DW-1:0] w_step;
    logic signed [SW-1:0] w_acc_next;
    logic signed [SW-1:0] w_out_full;

    // One extra bit on the difference keeps full-scale swings from wrapping.
    assign w_in_scaled = DW'(bus.in) <<< FRAC;
    assign w_diff      = w_in_scaled - DW'(r_acc);
    assign w_step      = w_diff >>> IIRCONST;

    // The step is bounded by the distance to the scaled input, so acc stays in range.
    assign w_acc_next  = r_acc + SW'(w_step);
    assign w_out_full  = w_acc_next >>> FRAC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_out <= '0;
        end else if (bus.write) begin
            r_acc <= w_acc_next;
            r_out <= N'(w_out_full);
        end
    end

    assign bus.out = r_out;

endmodule

// File: tb/tb_filter_iir.sv
// Scoreboard bench for filter_iir: directed samples, expected outputs queued, monitor compares.
module tb_filter_iir;

  localparam int NO_REF = 99999;

  logic clk;
  logic rst;
  logic chk_en;
  logic chk_q;

  int checks;
  int errors;
  longint m_acc;

  logic [15:0] exp_q[$];
  int          ref_q[$];

  filter_iir_if #(.N(16), .NI(16)) bus_if ();

  filter_iir dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_eq(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, $signed(act), $signed(exp));
    end
  endfunction

  function automatic void check_tol(input string name, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, exp, tol);
    end
  endfunction

  // driver tasks
  task automatic drive(input int x, input int spec);
    @(posedge clk);
    #1;
    bus_if.in    = 16'(x);
    bus_if.write = 1'b1;
    chk_en       = 1'b1;
    m_acc = m_acc + (((longint'(x) <<< 7) - m_acc) >>> 6);
    exp_q.push_back(16'(m_acc >>> 7));
    ref_q.push_back(spec);
  endtask

  task automatic idle(input int n, input bit chk);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_if.write = 1'b0;
      chk_en       = chk;
      if (chk) begin
        exp_q.push_back(16'(m_acc >>> 7));
        ref_q.push_back(NO_REF);
      end
    end
  endtask

  // monitor / scoreboard
  always @(posedge clk) chk_q <= chk_en;

  always @(negedge clk) begin
    logic [15:0] e;
    int r;
    if (chk_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        e = exp_q.pop_front();
        r = ref_q.pop_front();
        check_eq("out_exact", bus_if.out, e);
        if (r != NO_REF)
          check_tol("out_table", int'($signed(bus_if.out)), r, ((r < 0 ? -r : r) * 2) / 100 + 1);
      end
    end
  end

  int t10k[9]  = '{156, 310, 461, 610, 757, 901, 1043, 1183, 1321};
  int t20k[4]  = '{1613, 1900, 2183, 2461};
  int tzero[3] = '{2423, 2385, 2348};
  int mix_in[4]  = '{-1, 1, -1000, 2224};
  int mix_ref[4] = '{2311, 2275, 2224, 2224};

  initial begin
    checks       = 0;
    errors       = 0;
    m_acc        = 0;
    chk_en       = 1'b0;
    chk_q        = 1'b0;
    rst          = 1'b0;
    bus_if.in    = '0;
    bus_if.write = 1'b0;

    #2;
    check_eq("reset_out", bus_if.out, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) drive(10000, t10k[i]);
    for (int i = 0; i < 4; i++) drive(20000, t20k[i]);
    for (int i = 0; i < 3; i++) drive(0, tzero[i]);
    for (int i = 0; i < 4; i++) drive(mix_in[i], mix_ref[i]);
    idle(10, 1'b1);

    // full-scale positive, then full-scale negative
    for (int i = 0; i < 2000; i++) drive(32767, NO_REF);
    idle(2, 1'b0);
    @(negedge clk);
    check_tol("converge_pos", int'($signed(bus_if.out)), 32767, 1);

    for (int i = 0; i < 2000; i++) drive(-32768, NO_REF);
    idle(2, 1'b0);
    @(negedge clk);
    check_tol("converge_neg", int'($signed(bus_if.out)), -32768, 1);

    // mid-run reset, asserted while clk is high
    for (int i = 0; i < 5; i++) drive(5000, NO_REF);
    idle(2, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_reset_out", bus_if.out, 16'd0);
    m_acc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(10000, 156);
    drive(10000, 310);
    idle(3, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_iir.md
FILTER_IIR -- requirements
Module: FilterIIR

Interface
REQ-001 Parameter N, default 16: output width in bits, signed.
REQ-002 Parameter NI, default 16: input width in bits, signed.
REQ-003 Parameter IIRCONST, default 6: smoothing shift; filter coefficient alpha = 2^-IIRCONST.
REQ-004 Parameter FRAC, default 7: fractional bits kept in internal state; legal only when FRAC >= IIRCONST.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 in  input  NI  signed sample.
REQ-008 write  input  1  sample-valid strobe; one sample accepted per cycle while high.
REQ-009 out  output  N  signed filtered value, registered.

Function
REQ-010 SHALL hold signed state acc of NI+FRAC bits, representing acc/2^FRAC.
REQ-011 On a rising edge with write=1, SHALL compute acc_next = acc + ((in<<FRAC) - acc) >>> IIRCONST.
  - Arithmetic right shift, i.e. floor.
  - Difference computed in NI+FRAC+1 bits so no intermediate overflow.
REQ-012 On a rising edge with write=0, acc and out SHALL hold.
REQ-013 out SHALL be acc >>> FRAC (floor toward minus infinity), resized to N bits.
  - out is registered; it reflects the sample accepted at the same edge.
  - Latency one edge; out is valid shortly after the edge with no further delay.
REQ-014 Because |acc| never exceeds the full-scale input, acc SHALL never overflow for any input sequence.
REQ-015 Back-to-back write=1 cycles SHALL each be filtered; no gaps and no handshake back-pressure.
REQ-016 Constant input x SHALL converge so that out settles at floor(x) or floor(x)-1, with no limit cycle larger than 1 LSB of out.
REQ-017 Negative inputs SHALL be handled symmetrically through signed arithmetic.

Reset
REQ-018 While rst=0, acc and out SHALL be 0 immediately, independent of clk.
REQ-019 Reset asserted mid-stream SHALL discard all history; the first write after release SHALL behave as from a zero state.
REQ-020 Deassertion SHALL be synchronised by the integrator at system level; the block only requires rst stable around clk edges.

Structure
REQ-021 Default parameter values (16, 16, 6, 7) SHALL live in a shared package, along with a function giving the state width NI+FRAC.
REQ-022 Single flat module; no sub-module required.

Verification
REQ-023 Reset, then write 10000 for 9 cycles -> out follows 156, 310, 461, 610, 757, 901, 1043, 1183, 1321 (±2%).
REQ-024 Continue with write 20000 for 4 cycles -> 1613, 1900, 2183, 2461; then write 0 for 3 cycles -> 2423, 2385, 2348 (±2%).
REQ-025 Continue with -1, 1, -1000, 2224 -> 2311, 2275, 2224, 2224 (±2%); the last sample confirms steady state.
REQ-026 Write=0 for 10 cycles after any value -> out unchanged; assert rst=0 mid-run -> out=0 asynchronously, and the next write of 10000 gives 156.
REQ-027 Full-scale inputs +32767 and -32768 held for 2000 writes -> out converges to within 1 LSB of the input with no overflow or sign flip.
